// File: rtl/online_mult_pkg.sv
// Purpose : shared types and constants for the online-multiplier digit path.
// Latency : n/a (declarations only).
// Backpr. : n/a. Exports the reader state encoding and the skid buffer depth.
package online_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/digit_skid_fifo.sv
// Purpose : 2-entry FIFO of {last, digit} absorbing RAM read latency.
// Latency : a push is visible at the head the following cycle.
// Backpr. : no full flag; the issuer must never push into a full buffer without a pop.
// Ports   : push_i/push_last_i/push_dat_i in; pop_i in; count_o, head_last_o, head_dat_o out.
module digit_skid_fifo
  import online_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  push_last_i,
  input  logic [DATA_WIDTH-1:0] push_dat_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic                  head_last_o,
  output logic [DATA_WIDTH-1:0] head_dat_o
);

  logic [DATA_WIDTH:0] mem_q [SKID_DEPTH];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_dat_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // Simultaneous push and pop leave the count unchanged.
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign count_o     = count_q;
  assign head_last_o = mem_q[rd_ptr_q][DATA_WIDTH];
  assign head_dat_o  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];

endmodule

// File: rtl/single_clk_ram_4bit.sv
// Purpose : single-clock digit RAM, one write port and one read port.
// Latency : read address is registered, so q shows mem[addr] the cycle after addr.
// Backpr. : none; a read has no side effect.
// Ports   : clk; we/write_addr/data write port; read_addr in, q out.
module single_clk_ram_4bit #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] read_addr_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[write_addr] <= data;
    end
    read_addr_q <= read_addr;
  end

  assign q = mem_q[read_addr_q];

endmodule

// File: rtl/ram_digit_reader.sv
// Purpose : reads `length` digits from base_addr out of the digit RAM, streams them MSD-first.
// Latency : start in cycle S -> first dout_valid in S+3; one digit per cycle with dout_ready high.
// Backpr. : dout_ready low stalls the head; reads are throttled so the 2-entry skid never overflows.
// Ports   : start/base_addr/length request; busy/done status; ram_read_addr/ram_q RAM side;
//           dout/dout_valid/dout_ready/dout_last stream.
module ram_digit_reader
  import online_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  localparam logic [2:0]          SKID_LIMIT = 3'(SKID_DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH+1)'(1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic [ADDR_WIDTH:0]   delivered_q;
  logic [ADDR_WIDTH:0]   delivered_d;
  logic                  inflight_q;
  logic                  pend_last_q;
  logic                  busy_q;
  logic                  done_q;

  logic [1:0]            fifo_cnt;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_dat;
  logic                  pop;
  logic                  issue;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [2:0]            occ;
  logic                  drain_done;

  assign dout_valid = (fifo_cnt != 2'd0);
  assign pop        = dout_valid & dout_ready;
  assign dout       = head_dat;
  assign dout_last  = dout_valid & head_last;

  // Occupancy after this cycle's pop, counting the read whose data lands next cycle.
  assign occ        = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue      = (state_q == READ) && (occ < SKID_LIMIT);
  assign issue_last = ((issued_q + CNT_ONE) == len_q);
  // Address arithmetic wraps naturally at the RAM depth.
  assign issue_addr = base_q + issued_q[ADDR_WIDTH-1:0];
  // Hold the last address when idle; the RAM read has no side effect.
  assign ram_read_addr = issue ? issue_addr : addr_q;

  assign delivered_d = pop ? (delivered_q + CNT_ONE) : delivered_q;
  // Leave DRAIN in the same cycle the final digit is handshaken.
  assign drain_done  = (state_q == DRAIN) && !inflight_q &&
                       (fifo_cnt == {1'b0, pop}) && (delivered_d == len_q);

  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      pend_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      inflight_q  <= issue;
      pend_last_q <= issue & issue_last;
      delivered_q <= delivered_d;
      if (issue) begin
        addr_q   <= issue_addr;
        issued_q <= issued_q + CNT_ONE;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q      <= base_addr;
            len_q       <= length;
            issued_q    <= '0;
            delivered_q <= '0;
            busy_q      <= 1'b1;
            if (length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (issue && issue_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  digit_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_last_i(pend_last_q),
    .push_dat_i (ram_q),
    .pop_i      (pop),
    .count_o    (fifo_cnt),
    .head_last_o(head_last),
    .head_dat_o (head_dat)
  );

endmodule

// File: tb/tb_ram_digit_reader.sv
// Purpose : randomized, scoreboard-checked bench for ram_digit_reader with the digit RAM.
// Latency : checks first-digit and done timing for unstalled transfers.
// Backpr. : drives dout_ready always-high, 1-0-0 pattern, or random.
module tb_ram_digit_reader;

  localparam int DW    = 4;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_q, dout;
  logic          dout_valid, dout_last;
  logic          dout_ready = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int valid_cnt = 0;
  int first_valid_cyc = -1;
  bit saw127 = 0;
  bit saw_wrap = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_dout;
  logic          prev_last;
  logic [DW:0]   exp_e;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW:0]   exp_q [$];

  ram_digit_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .ram_read_addr(ram_read_addr),
    .ram_q        (ram_q),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_last    (dout_last)
  );

  single_clk_ram_4bit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_ram (
    .clk       (clk),
    .we        (we),
    .write_addr(waddr),
    .data      (wdata),
    .read_addr (ram_read_addr),
    .q         (ram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (dout_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) begin
        chk("stall_valid", int'(dout_valid), 1);
        chk("stall_dout", int'(dout), int'(prev_dout));
        chk("stall_last", int'(dout_last), int'(prev_last));
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_digit", int'(dout), -1);
        end else begin
          exp_e = exp_q.pop_front();
          chk("dout", int'(dout), int'(exp_e[DW-1:0]));
          chk("dout_last", int'(dout_last), int'(exp_e[DW]));
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ram_read_addr == AW'(127)) saw127 = 1'b1;
      else if (saw127 && ram_read_addr == '0) saw_wrap = 1'b1;
    end
  end

  // Consumer readiness.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: dout_ready = 1'b1;
        1: begin
          dout_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: dout_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  task automatic wr(input int a, input int d);
    we = 1'b1; waddr = AW'(a); wdata = DW'(d);
    @(posedge clk); #1;
    we = 1'b0;
    model_mem[a] = DW'(d);
  endtask

  task automatic push_expected(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(k == n - 1) ? 1'b1 : 1'b0, model_mem[(b + k) % DEPTH]});
    end
  endtask

  task automatic xfer(input int b, input int n, input bit timing, input string tag);
    int s, d0, i;
    push_expected(b, n);
    d0 = done_cnt; first_valid_cyc = -1; done_cyc = -1;
    base_addr = AW'(b); length = (AW+1)'(n); start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom); length = (AW+1)'($urandom);
    i = 0;
    while (done_cnt == d0 && i < 4 * n + 40) begin
      @(posedge clk); #1;
      i++;
    end
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
    chk({tag, "_idle_after_done"}, int'(busy), 0);
    if (timing) begin
      chk({tag, "_first_valid_lat"}, first_valid_cyc - s, 3);
      chk({tag, "_done_lat"}, done_cyc - s, 3 + n);
    end
    @(posedge clk); #1;
    chk({tag, "_single_done"}, done_cnt - d0, 1);
    chk({tag, "_all_delivered"}, exp_q.size(), 0);
  endtask

  initial begin
    int s, d0, v0, b, n;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_last", int'(dout_last), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_addr", int'(ram_read_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < DEPTH; a++) wr(a, a % 16);

    // Basic transfer.
    ready_mode = 0;
    xfer(5, 4, 1'b1, "basic");

    // Address wrap.
    wr(126, 'hA); wr(127, 'hB); wr(0, 'hC); wr(1, 'hD);
    saw127 = 1'b0; saw_wrap = 1'b0;
    xfer(126, 4, 1'b1, "wrap");
    chk("wrap_addr_127_to_0", int'(saw_wrap), 1);

    // Backpressure 1,0,0 pattern.
    ready_mode = 1;
    xfer(40, 10, 1'b0, "stall");
    ready_mode = 0;

    // Zero length, then a start during DONE that must be ignored.
    d0 = done_cnt; v0 = valid_cnt; done_cyc = -1;
    base_addr = '0; length = '0; start = 1'b1; s = cyc;
    @(posedge clk); #1;
    chk("len0_done_now", int'(done), 1);
    length = (AW+1)'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("len0_done_lat", done_cyc - s, 1);
    chk("len0_single_done", done_cnt - d0, 1);
    chk("len0_no_valid", valid_cnt - v0, 0);
    chk("len0_start_in_done_ignored", int'(busy), 0);

    // Full-depth transfer with a start while busy.
    v0 = valid_cnt;
    fork
      xfer(0, 128, 1'b1, "full");
      begin
        repeat (10) @(posedge clk);
        #1;
        base_addr = AW'(50); length = (AW+1)'(5); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("full_digit_count", valid_cnt - v0, 128);
    chk("full_busy_start_ignored", int'(busy), 0);

    // Reset in the middle of a transfer.
    push_expected(20, 8);
    d0 = done_cnt;
    base_addr = AW'(20); length = (AW+1)'(8); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_last", int'(dout_last), 0);
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_addr", int'(ram_read_addr), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_idle", int'(busy), 0);
    xfer(3, 6, 1'b1, "post_rst");

    // Randomized transfers.
    for (int r = 0; r < 10; r++) begin
      for (int w = 0; w < 3; w++) wr($urandom % DEPTH, $urandom % 16);
      ready_mode = $urandom % 3;
      b = $urandom % DEPTH;
      n = 1 + ($urandom % 20);
      xfer(b, n, ready_mode == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/ram_digit_reader.md
# ram_digit_reader

Read-side controller for the single-clock 4-bit digit RAM used by the online multiplier. On a `start` pulse it reads `length` consecutive digits from the RAM, starting at `base_addr`, and streams them out MSD-first over a valid/ready interface. It absorbs the RAM's one-cycle registered-address read latency and downstream backpressure with a 2-entry skid buffer, so a consumer holding `dout_ready` high gets one digit per cycle.

## Interface
- `DATA_WIDTH`, default 4: digit width; equals the RAM data width.
- `ADDR_WIDTH`, default 7: RAM address width; depth is 2**ADDR_WIDTH.
- `clk`  in  1  rising-edge clock; shared with the RAM.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first address; captured with `start`.
- `length`  in  ADDR_WIDTH+1  digit count, 0..2**ADDR_WIDTH; captured with `start`.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse at the end of a transfer.
- `ram_read_addr`  out  ADDR_WIDTH  drives the RAM read address.
- `ram_q`  in  DATA_WIDTH  RAM read data; valid the cycle after its address is presented.
- `dout`  out  DATA_WIDTH  output digit.
- `dout_valid`  out  1  `dout` holds a valid digit.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `dout_last`  out  1  qualifies the final digit of the transfer.

## Operation
- States:
  - IDLE → READ on `start` with `length`≠0.
  - IDLE → DONE on `start` with `length`=0.
  - READ → DRAIN when the last read has been issued.
  - DRAIN → DONE when the skid buffer is empty, nothing is in flight, and the last digit has been handshaken.
  - DONE → IDLE unconditionally.
- `done`=1 only in DONE. `busy`=1 in READ, DRAIN and DONE.
- Read issue:
  - In READ, issue a read when (fifo_count + inflight − pop) < 2, where pop = `dout_valid & dout_ready`.
  - An issued read drives `ram_read_addr` = base + issued_count, modulo 2**ADDR_WIDTH (wraps 127→0).
  - inflight is a 1-bit register set in the issuing cycle. The next cycle, `ram_q` is pushed into the skid buffer.
- Skid buffer:
  - 2 entries, FIFO order.
  - `dout`/`dout_valid` come from the head entry.
  - Push and pop in the same cycle are both honoured.
  - It never overflows, by the issue rule.
- `dout_last` = `dout_valid` & (the head digit is digit number `length`−1). A per-entry last flag is tracked.
- A `start` while busy is ignored. `base_addr`/`length` changing mid-transfer have no effect.
- Counters: issued_count and delivered_count are ADDR_WIDTH+1 bits, so `length`=128 is representable.
- `ram_read_addr` is held at its last value when not issuing. This is harmless because the RAM's read has no side effect.
- RAM write collisions are not arbitrated here. Data returned is whatever the RAM presents.

## Timing
- Reset values (async reset, all outputs and state): state IDLE; `busy`, `done`, `dout_valid`, `dout_last` = 0; `dout` = 0; `ram_read_addr` = 0; counters, inflight and FIFO cleared.
- Reset asserted mid-transfer aborts immediately. No `done` is produced and the buffered digits are discarded.
- Cycle S: `start` sampled. Cycle S+1: READ, first address driven. Cycle S+2: `ram_q` valid and pushed. Cycle S+3: first `dout_valid`.
- With `dout_ready` held high, digits appear on consecutive cycles S+3 … S+2+`length`. `done` is asserted in cycle S+3+`length`, and IDLE follows in the next cycle.
- With `length`=0: `done` in S+1, with no `dout_valid`.
- `dout` and `dout_last` stay stable while `dout_valid & !dout_ready`.

## Structure
- Shared package `online_mult_pkg`:
  - state enum (IDLE, READ, DRAIN, DONE);
  - constant SKID_DEPTH = 2.
- Sub-module `digit_skid_fifo`: 2-entry FIFO of {last, digit}, with push, pop, count, head outputs and async active-low reset.
- The top level contains the FSM, the counters, the issue logic, and one `digit_skid_fifo` instance.
- The bench instantiates the reader together with `single_clk_ram_4bit` (DATA_WIDTH=4, ADDR_WIDTH=7).

## Test plan
- Preload mem[i]=i%16; `base_addr`=5, `length`=4, `dout_ready`=1 → `dout` 5,6,7,8 at S+3..S+6; `dout_last` only with 8; `done` at S+7.
- `base_addr`=126, `length`=4, mem[126]=0xA, mem[127]=0xB, mem[0]=0xC, mem[1]=0xD → A,B,C,D; address wraps 127→0.
- `length`=10 with `dout_ready` toggling 1,0,0,1,… → all 10 digits delivered in order, none lost or duplicated; `dout` stable while stalled; at most 2 buffered.
- `length`=0 → `done` at S+1, `dout_valid` never asserted; a `start` pulsed again in the DONE cycle is ignored.
- `length`=128, `base_addr`=0 → 128 digits delivered, `dout_last` on digit 127; a second `start` while busy is ignored.
- `rst_n` pulled low at S+5 of a `length`=8 transfer → all outputs return to their reset values immediately; no `done`; a fresh transfer after reset works.
